// File: rtl/regfile.sv
// rtl/regfile.sv - register file with two combinational read ports, one write port and NZP condition codes.
// Optional write-through forwarding on the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [DATA_W-1:0]    wdata,
  input  logic                 setcc,
  input  logic [ADDR_W-1:0]    raddr1,
  output logic [DATA_W-1:0]    rdata1,
  input  logic [ADDR_W-1:0]    raddr2,
  output logic [DATA_W-1:0]    rdata2,
  output logic [2**ADDR_W-1:0] wsel,
  output logic [2:0]           nzp
);

  localparam int NUM_REGS = 2**ADDR_W;

  localparam logic [2:0] CC_N = 3'b100;
  localparam logic [2:0] CC_Z = 3'b010;
  localparam logic [2:0] CC_P = 3'b001;

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [2:0]          r_nzp;
  logic [NUM_REGS-1:0] w_wsel;
  logic [2:0]          w_cc;

  always_comb begin
    w_wsel = '0;
    if (we) begin
      w_wsel[waddr] = 1'b1;
    end
  end

  always_comb begin
    if (wdata[DATA_W-1]) begin
      w_cc = CC_N;
    end else if (wdata == '0) begin
      w_cc = CC_Z;
    end else begin
      w_cc = CC_P;
    end
  end

  // Reset wins over a coincident write, so every register clears together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_wsel[i]) begin
          r_regs[i] <= wdata;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nzp <= CC_Z;
    end else if (we && setcc) begin
      r_nzp <= w_cc;
    end
  end

  always_comb begin
    rdata1 = r_regs[raddr1];
    rdata2 = r_regs[raddr2];
`ifdef REGFILE_BYPASS_EN
    if (we && (raddr1 == waddr)) begin
      rdata1 = wdata;
    end
    if (we && (raddr2 == waddr)) begin
      rdata2 = wdata;
    end
`endif
  end

  assign wsel = w_wsel;
  assign nzp  = r_nzp;

endmodule

// File: tb/tb_regfile.sv
// tb/tb_regfile.sv - randomized self-checking bench for regfile against an array-based reference model.
module tb_regfile;

  logic        clk;
  logic        rst;
  logic        we;
  logic [2:0]  waddr;
  logic [15:0] wdata;
  logic        setcc;
  logic [2:0]  raddr1;
  logic [2:0]  raddr2;
  logic [15:0] rdata1;
  logic [15:0] rdata2;
  logic [7:0]  wsel;
  logic [2:0]  nzp;

  logic        we4;
  logic [3:0]  waddr4;
  logic [7:0]  wdata4;
  logic        setcc4;
  logic [3:0]  raddr4_1;
  logic [3:0]  raddr4_2;
  logic [7:0]  rdata4_1;
  logic [7:0]  rdata4_2;
  logic [15:0] wsel4;
  logic [2:0]  nzp4;

  int total;
  int bad;

  logic [15:0] m_regs [8];
  logic [2:0]  m_nzp;

  regfile u_dut (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .setcc(setcc),
    .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2),
    .wsel(wsel), .nzp(nzp)
  );

  regfile #(.ADDR_W(4), .DATA_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .we(we4), .waddr(waddr4), .wdata(wdata4), .setcc(setcc4),
    .raddr1(raddr4_1), .rdata1(rdata4_1), .raddr2(raddr4_2), .rdata2(rdata4_2),
    .wsel(wsel4), .nzp(nzp4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] cc_of(input logic [15:0] v);
    if (v >= 16'h8000) return 3'b100;
    if (v == 16'h0000) return 3'b010;
    return 3'b001;
  endfunction

  function automatic logic [15:0] exp_rd(input logic [2:0] a);
`ifdef REGFILE_BYPASS_EN
    if (we && a == waddr) return wdata;
`endif
    return m_regs[a];
  endfunction

  function automatic logic [7:0] exp_wsel();
    return we ? (8'h01 << waddr) : 8'h00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_nzp = 3'b010;
  endtask

  task automatic check_comb();
    check("wsel", {24'h0, wsel}, {24'h0, exp_wsel()});
    check("rdata1", {16'h0, rdata1}, {16'h0, exp_rd(raddr1)});
    check("rdata2", {16'h0, rdata2}, {16'h0, exp_rd(raddr2)});
  endtask

  // One cycle: drive at negedge, check combinational outputs, clock, update model, check nzp.
  task automatic drive(input logic w, input logic [2:0] wa, input logic [15:0] wd,
                       input logic sc, input logic [2:0] r1, input logic [2:0] r2);
    @(negedge clk);
    we = w; waddr = wa; wdata = wd; setcc = sc; raddr1 = r1; raddr2 = r2;
    #1;
    check_comb();
    @(posedge clk);
    if (!rst) begin
      if (w) m_regs[wa] = wd;
      if (w && sc) m_nzp = cc_of(wd);
    end
    #1;
    check("nzp", {29'h0, nzp}, {29'h0, m_nzp});
    check("nzp_onehot", {31'h0, $onehot(nzp)}, 32'h1);
  endtask

  initial begin
    logic [15:0] rv;
    total = 0;
    bad = 0;
    rst = 1'b1;
    we = 1'b0; waddr = '0; wdata = '0; setcc = 1'b0; raddr1 = '0; raddr2 = '0;
    we4 = 1'b0; waddr4 = '0; wdata4 = '0; setcc4 = 1'b0; raddr4_1 = '0; raddr4_2 = '0;
    model_reset();

    // Reset state, then release.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      raddr1 = i[2:0];
      raddr2 = 3'(7 - i);
      #1;
      check("rst_rd1", {16'h0, rdata1}, 32'h0);
      check("rst_rd2", {16'h0, rdata2}, 32'h0);
    end
    check("rst_nzp", {29'h0, nzp}, 32'h2);
    check("rst_wsel", {24'h0, wsel}, 32'h0);
    check("rst_nzp4", {29'h0, nzp4}, 32'h2);
    rst = 1'b0;

    drive(1'b1, 3'd3, 16'h1234, 1'b1, 3'd3, 3'd0);
    check("wr3_nzp", {29'h0, nzp}, 32'h1);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd3, 3'd4);
    check("wr3_rd", {16'h0, rdata1}, 32'h1234);

    drive(1'b1, 3'd5, 16'h8000, 1'b1, 3'd5, 3'd6);
    check("cc_n", {29'h0, nzp}, 32'h4);
    drive(1'b1, 3'd6, 16'h0000, 1'b1, 3'd5, 3'd6);
    check("cc_z", {29'h0, nzp}, 32'h2);
    drive(1'b1, 3'd7, 16'h0001, 1'b0, 3'd7, 3'd5);
    check("cc_hold_we", {29'h0, nzp}, 32'h2);
    drive(1'b0, 3'd7, 16'h8001, 1'b1, 3'd7, 3'd5);
    check("cc_hold_sc", {29'h0, nzp}, 32'h2);

    // Same-cycle read of the register being written.
    drive(1'b1, 3'd2, 16'h0011, 1'b0, 3'd0, 3'd1);
    @(negedge clk);
    we = 1'b1; waddr = 3'd2; wdata = 16'hBEEF; setcc = 1'b0; raddr1 = 3'd2; raddr2 = 3'd2;
    #1;
`ifdef REGFILE_BYPASS_EN
    rv = 16'hBEEF;
`else
    rv = 16'h0011;
`endif
    check("rw_same_rd1", {16'h0, rdata1}, {16'h0, rv});
    check("rw_same_rd2", {16'h0, rdata2}, {16'h0, rv});
    @(posedge clk);
    m_regs[2] = 16'hBEEF;
    @(negedge clk);
    we = 1'b0;
    #1;
    check("rw_next_rd1", {16'h0, rdata1}, 32'hBEEF);
    check("rw_next_rd2", {16'h0, rdata2}, 32'hBEEF);

    // Asynchronous reset between edges with a write pending.
    drive(1'b1, 3'd1, 16'h00AA, 1'b1, 3'd1, 3'd1);
    @(negedge clk);
    we = 1'b1; waddr = 3'd1; wdata = 16'h00FF; setcc = 1'b1; raddr1 = 3'd1; raddr2 = 3'd3;
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_rd1", {16'h0, rdata1}, {16'h0, exp_rd(3'd1)});
    check("arst_rd2", {16'h0, rdata2}, 32'h0);
    check("arst_nzp", {29'h0, nzp}, 32'h2);
    @(posedge clk);
    #1;
    check("arst_edge_rd1", {16'h0, rdata1}, {16'h0, exp_rd(3'd1)});
    check("arst_edge_nzp", {29'h0, nzp}, 32'h2);
    @(negedge clk);
    we = 1'b0;
    rst = 1'b0;
    #1;
    check("arst_rel_rd1", {16'h0, rdata1}, 32'h0);
    drive(1'b1, 3'd1, 16'h0042, 1'b1, 3'd1, 3'd1);
    drive(1'b0, 3'd0, 16'h0, 1'b0, 3'd1, 3'd0);
    check("arst_resume", {16'h0, rdata1}, 32'h0042);

    // Randomized traffic with extra weight on condition-code corners.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: rv = 16'h0000;
        1: rv = 16'h8000 | 16'($urandom);
        default: rv = 16'($urandom);
      endcase
      drive(1'($urandom_range(0, 3) != 0), 3'($urandom), rv, 1'($urandom),
            3'($urandom), 3'($urandom));
    end

    // Wide configuration: 16 registers of 8 bits.
    @(negedge clk);
    we4 = 1'b1; waddr4 = 4'd15; wdata4 = 8'h7F; setcc4 = 1'b1; raddr4_1 = 4'd15; raddr4_2 = 4'd0;
    #1;
    check("w4_wsel", {16'h0, wsel4}, 32'h8000);
    @(posedge clk);
    @(negedge clk);
    we4 = 1'b1; waddr4 = 4'd0; wdata4 = 8'h80; setcc4 = 1'b1;
    #1;
    check("w4_rd15", {24'h0, rdata4_1}, 32'h7F);
    check("w4_nzp_p", {29'h0, nzp4}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    we4 = 1'b0;
    #1;
    check("w4_rd0", {24'h0, rdata4_2}, 32'h80);
    check("w4_nzp_n", {29'h0, nzp4}, 32'h4);
    check("w4_wsel_idle", {16'h0, wsel4}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile.md
REGFILE -- requirements
Module: regfile

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, the register address width; register count NUM_REGS = 2**ADDR_W.
REQ-002 SHALL have parameter DATA_W, default 16, the register data width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset; asynchronous and active-high.
REQ-005 SHALL have port we, input, 1, write enable.
REQ-006 SHALL have port waddr, input, ADDR_W, write register index.
REQ-007 SHALL have port wdata, input, DATA_W, write data.
REQ-008 SHALL have port setcc, input, 1, load condition codes from wdata on this write.
REQ-009 SHALL have port raddr1, input, ADDR_W, read port 1 index.
REQ-010 SHALL have port rdata1, output, DATA_W, read port 1 data.
REQ-011 SHALL have port raddr2, input, ADDR_W, read port 2 index.
REQ-012 SHALL have port rdata2, output, DATA_W, read port 2 data.
REQ-013 SHALL have port wsel, output, NUM_REGS, one-hot write select.
REQ-014 SHALL have port nzp, output, 3, condition codes {N,Z,P}, registered.

Function
REQ-015 SHALL decode waddr to wsel combinationally: bit waddr high when we=1; all zero when we=0.
REQ-016 SHALL write wdata into register waddr on a rising clk edge when we=1; all other registers hold.
REQ-017 SHALL present register contents on rdata1/rdata2 combinationally from raddr1/raddr2; zero-cycle read latency.
REQ-018 SHALL let both read ports address the same register, or the write register, in the same cycle with no conflict.
REQ-019 SHALL load nzp on a rising edge only when we=1 and setcc=1: 3'b100 if wdata[DATA_W-1]=1; 3'b010 if wdata=0; 3'b001 otherwise.
REQ-020 SHALL hold nzp when setcc=1 and we=0, and when we=1 and setcc=0.
REQ-021 SHALL keep nzp exactly one-hot at all times after reset.
REQ-022 SHALL, with no bypass compiled in, return the pre-write value on a read port that addresses waddr in the cycle of the write; the new value appears the cycle after the edge.

Reset
REQ-023 SHALL, while rst=1, force all NUM_REGS registers to 0 and nzp to 3'b010, independent of clk.
REQ-024 SHALL give reset priority over a simultaneous write: a write with we=1 at an edge where rst=1 is discarded.
REQ-025 SHALL drive rdata1/rdata2 to 0 during reset, unless bypass forwarding applies per REQ-027.
REQ-026 SHALL resume normal writes on the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL, when macro REGFILE_BYPASS_EN is defined, forward wdata to any read port whose address equals waddr while we=1 (write-through read); rdata reflects wdata in the write cycle.
REQ-028 SHALL, when REGFILE_BYPASS_EN is undefined, contain no forwarding path and follow REQ-022.

Verification
REQ-029 SHALL cover: rst=1 then release -> all 8 registers read 0, nzp=3'b010, wsel=8'h00.
REQ-030 SHALL cover: we=1, waddr=3, wdata=16'h1234, setcc=1 -> wsel=8'h08 in cycle; R3=16'h1234 and nzp=3'b001 next cycle; others still 0.
REQ-031 SHALL cover: write R5=16'h8000 with setcc=1, then R6=16'h0000 with setcc=1 -> nzp=3'b100, then nzp=3'b010; then write R7=16'h0001 with setcc=0 -> nzp stays 3'b010.
REQ-032 SHALL cover: raddr1=raddr2=waddr=2, we=1, wdata=16'hBEEF, R2 previously 16'h0011 -> rdata=16'h0011 in write cycle without REGFILE_BYPASS_EN, 16'hBEEF with it; both give 16'hBEEF next cycle.
REQ-033 SHALL cover: rst asserted mid-cycle between edges with we=1, waddr=1, wdata=16'h00FF pending -> R1 reads 0 immediately and after the edge; nzp=3'b010.
REQ-034 SHALL cover: ADDR_W=4, DATA_W=8; write R15=8'h7F, setcc=1 -> wsel=16'h8000; R15=8'h7F; nzp=3'b001.
